regfile: RTL and testbench

- General-purpose register file that serves the decode stage's two read requests (enable, address, data) and accepts the write-back stage's register write (enable, address, data).
- 32 x 32-bit MIPS registers; $0 reads as zero and ignores writes.
- Read ports are combinational, with same-cycle write-to-read bypass, so decode never sees stale data from a write that is retiring this cycle.
- The storage array has a single write port, so it is RAM-inferrable. A post-reset clear sequencer zeroes entries 1..31 one per cycle. `ready` gates the pipeline until clearing is done.

---
 rtl/cpu_defs_pkg.sv | 15 +
 rtl/regfile.sv | 104 ++++++++++
 tb/tb_regfile.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, the hardwired zero register and
// the register-file sequencer state encoding. Decode and write-back use these too.
package cpu_defs;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file with two combinational read ports, write-to-read
// bypass and a post-reset sequencer that zeroes entries 1..depth-1 through the write port.
module regfile
   import cpu_defs::ZERO_REG;
   import cpu_defs::rf_state_e;
   import cpu_defs::CLEAR;
   import cpu_defs::RUN;
#(
   parameter int unsigned DATA_W = cpu_defs::DATA_W,
   parameter int unsigned ADDR_W = cpu_defs::REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= ADDR_W'(1);
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         if (clr_cnt_q == '1) begin
            state_d = RUN;
         end
      end
   end

   // Single array write port: the clear sequencer owns it until RUN, then write-back.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
         end else if (we && waddr != ADDR_W'(ZERO_REG)) begin
            mem_we    = 1'b1;
            mem_waddr = waddr;
            mem_wdata = wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic              en;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] data;

      assign en = (p == 0) ? re1 : re2;
      assign ra = (p == 0) ? raddr1 : raddr2;

      always_comb begin
         data = '0;
         if (!rst && state_q == RUN && en && ra != ADDR_W'(ZERO_REG)) begin
            if (we && waddr == ra) begin
               data = wdata;
            end else begin
               data = mem_q[ra];
            end
         end
      end
   end

   assign rdata1 = g_rd[0].data;
   assign rdata2 = g_rd[1].data;
   assign ready  = (state_q == RUN);

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed clear/reset sequences, a vector table
// and randomized traffic compared against an array-based reference model.
module tb_regfile;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst, we, re1, re2, ready;
   logic [AW-1:0] waddr, raddr1, raddr2;
   logic [DW-1:0] wdata, rdata1, rdata2;

   always #5 clk = ~clk;

   regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .ready(ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: register contents plus how many clear cycles remain.
   logic [DW-1:0] m_mem [32];
   bit            m_ready;
   int            m_clr_left;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          re1;
      logic [AW-1:0] ra1;
      logic          re2;
      logic [AW-1:0] ra2;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } vec_t;

   vec_t vt [10];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input logic ren, input logic [AW-1:0] a);
      if (rst || !m_ready || !ren || a == 0) return '0;
      if (we && waddr == a) return wdata;
      return m_mem[a];
   endfunction

   function automatic void model_edge();
      if (rst) begin
         m_clr_left = 31;
         m_ready    = 1'b0;
      end else if (!m_ready) begin
         m_mem[32 - m_clr_left] = '0;
         m_clr_left--;
         if (m_clr_left == 0) m_ready = 1'b1;
      end else if (we && waddr != 0) begin
         m_mem[waddr] = wdata;
      end
   endfunction

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("ready", DW'(ready), DW'(m_ready));
   endtask

   task automatic idle();
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
   endtask

   task automatic check_reads(input string tag);
      #1;
      check({tag, " rdata1"}, rdata1, m_read(re1, raddr1));
      check({tag, " rdata2"}, rdata2, m_read(re2, raddr2));
   endtask

   task automatic wait_ready(input string tag, input int exp_cycles);
      int n = 0;
      while (!ready && n < 40) begin
         cycle();
         n++;
      end
      check({tag, " clear cycles"}, DW'(n), DW'(exp_cycles));
   endtask

   task automatic read_zero(input string tag, input logic [AW-1:0] a);
      re1 = 1'b1; raddr1 = a; re2 = 1'b1; raddr2 = a;
      #1;
      check({tag, " rd1 zero"}, rdata1, 32'h0);
      check({tag, " rd2 zero"}, rdata2, 32'h0);
      cycle();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_ready    = 1'b0;
      m_clr_left = 31;
      idle();

      // Reset / clear timing: ready stays low for exactly 31 edges after release.
      rst = 1'b1;
      repeat (3) cycle();
      check("ready in reset", DW'(ready), 32'h0);
      rst = 1'b0;
      wait_ready("init", 31);
      for (int a = 1; a < 32; a++) read_zero("init clr", AW'(a));
      idle();

      vt[0] = '{1'b1, 5'd5,  32'h12345678, 1'b1, 5'd5,  1'b0, 5'd0,  32'h12345678, 32'h0};
      vt[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'h12345678, 32'h12345678};
      vt[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd5,  32'h0,        32'h12345678};
      vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
      vt[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
      vt[5] = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  1'b0, 5'd7,  32'hAAAA0000, 32'h0};
      vt[6] = '{1'b1, 5'd7,  32'h0000BEEF, 1'b1, 5'd7,  1'b1, 5'd7,  32'h0000BEEF, 32'h0000BEEF};
      vt[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd5,  32'h0000BEEF, 32'h12345678};
      vt[8] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd30, 1'b1, 5'd31, 32'h0,        32'h00000001};
      vt[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd30, 32'h00000001, 32'h0};
      for (int i = 0; i < 10; i++) begin
         we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
         re1 = vt[i].re1; raddr1 = vt[i].ra1; re2 = vt[i].re2; raddr2 = vt[i].ra2;
         #1;
         check($sformatf("vec%0d rdata1", i), rdata1, vt[i].e1);
         check($sformatf("vec%0d rdata2", i), rdata2, vt[i].e2);
         cycle();
      end
      idle();

      // Writes during clear are dropped.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (5) cycle();
      we = 1'b1; waddr = 5'd31; wdata = 32'hDEADBEEF; re1 = 1'b1; raddr1 = 5'd31;
      #1;
      check("clr write rd1", rdata1, 32'h0);
      check("clr write ready", DW'(ready), 32'h0);
      cycle();
      idle();
      wait_ready("clr write", 25);
      read_zero("clr write r31", 5'd31);

      // Reset mid-run restarts the clear.
      for (int r = 1; r <= 3; r++) begin
         we = 1'b1; waddr = AW'(r); wdata = 32'h100 * r + 32'h5A;
         cycle();
      end
      we = 1'b0; re1 = 1'b1; raddr1 = 5'd2;
      #1;
      check("pre-rst r2", rdata1, 32'h25A);
      rst = 1'b1; re2 = 1'b1; raddr2 = 5'd3;
      #1;
      check("rst rd1", rdata1, 32'h0);
      check("rst rd2", rdata2, 32'h0);
      cycle();
      check("rst ready low", DW'(ready), 32'h0);
      idle();
      wait_ready("midrun", 31);
      for (int r = 1; r <= 3; r++) read_zero("midrun", AW'(r));
      idle();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst    = ($urandom_range(0, 249) == 0);
         we     = $urandom_range(0, 1);
         waddr  = AW'($urandom);
         wdata  = $urandom;
         re1    = ($urandom_range(0, 3) != 0);
         re2    = ($urandom_range(0, 3) != 0);
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
         raddr2 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
         check_reads($sformatf("rand%0d", i));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
